// File: rtl/raizing_sndcmd_tx.sv
// Sound command transmitter for the 68k side. Commands are queued in a small FIFO,
// then shown on SOUNDLATCH one at a time with a Z80INT pulse and an ack/timeout handshake.
module raizing_sndcmd_tx #(
  parameter int unsigned DEPTH_LOG2  = 2,
  parameter int unsigned INT_PULSE   = 8,
  parameter int unsigned ACK_TIMEOUT = 960000
) (
  input  logic                  CLK96,
  input  logic                  RESET96,
  input  logic                  M68K_WR,
  input  logic                  M68K_RD,
  input  logic                  M68K_A,
  input  logic [7:0]            M68K_DIN,
  output logic [7:0]            M68K_DOUT,
  output logic [7:0]            SOUNDLATCH,
  output logic                  Z80INT,
  input  logic                  SND_ACK,
  output logic                  PENDING,
  output logic [DEPTH_LOG2:0]   LEVEL
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StInt, StWaitAck, StGap} state_e;

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q;

  state_e      state_q;
  logic [23:0] cnt_q;
  logic        ack_seen_q;
  logic        ovf_q;
  logic        to_q;
  logic        z80int_q;
  logic        pending_q;
  logic [7:0]  soundlatch_q;
  logic [7:0]  dout_q;

  logic       push_req, ctrl_wr, flush, clr_flags;
  logic       fifo_empty, fifo_full;
  logic       push, pop, drop;
  logic [7:0] head;
  logic [2:0] level3;
  logic [7:0] status;

  always_comb begin
    push_req   = M68K_WR & ~M68K_A;
    ctrl_wr    = M68K_WR & M68K_A;
    flush      = ctrl_wr & M68K_DIN[1];
    clr_flags  = ctrl_wr & M68K_DIN[0];
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LvlW'(Depth));
    pop        = (state_q == StLoad) & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    push       = push_req & ~flush & (~fifo_full | pop);
    drop       = push_req & ~flush & fifo_full & ~pop;
    head       = mem_q[rd_ptr_q];
    level3     = 3'(level_q);
    status     = {ovf_q, to_q, 2'b00, pending_q, level3};
  end

  always_ff @(posedge CLK96) begin
    if (push) begin
      mem_q[wr_ptr_q] <= M68K_DIN;
    end
  end

  always_ff @(posedge CLK96) begin
    if (RESET96 || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      dout_q <= 8'h00;
    end else if (M68K_RD) begin
      dout_q <= M68K_A ? soundlatch_q : status;
    end
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ack_seen_q   <= 1'b0;
      ovf_q        <= 1'b0;
      to_q         <= 1'b0;
      z80int_q     <= 1'b0;
      pending_q    <= 1'b0;
      soundlatch_q <= 8'h00;
    end else begin
      if (clr_flags) begin
        ovf_q <= 1'b0;
        to_q  <= 1'b0;
      end
      if (drop) ovf_q <= 1'b1;

      case (state_q)
        StIdle: begin
          ack_seen_q <= 1'b0;
          cnt_q      <= '0;
          if (!fifo_empty) state_q <= StLoad;
        end
        StLoad: begin
          // The queue can be flushed between IDLE and LOAD; nothing to issue then.
          if (fifo_empty) begin
            state_q <= StIdle;
          end else begin
            soundlatch_q <= head;
            z80int_q     <= 1'b1;
            pending_q    <= 1'b1;
            ack_seen_q   <= SND_ACK;
            cnt_q        <= '0;
            state_q      <= StInt;
          end
        end
        StInt: begin
          if (SND_ACK) ack_seen_q <= 1'b1;
          if (cnt_q == 24'(INT_PULSE - 1)) begin
            z80int_q <= 1'b0;
            cnt_q    <= '0;
            if (ack_seen_q || SND_ACK) begin
              pending_q <= 1'b0;
              state_q   <= StGap;
            end else begin
              state_q <= StWaitAck;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StWaitAck: begin
          if (SND_ACK) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StGap;
          end else if (cnt_q == 24'(ACK_TIMEOUT - 1)) begin
            to_q      <= 1'b1;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StGap;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StGap: begin
          // Two low cycles, then straight into LOAD if work is queued.
          if (cnt_q == 24'd1) begin
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
            state_q    <= fifo_empty ? StIdle : StLoad;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign M68K_DOUT  = dout_q;
  assign SOUNDLATCH = soundlatch_q;
  assign Z80INT     = z80int_q;
  assign PENDING    = pending_q;
  assign LEVEL      = level_q;

endmodule
